// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over 32 cycles, finishing with a one-cycle register-file write request.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic            w_en,
    output logic [4:0]      w_addr,
    output logic [XLEN-1:0] w_data
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [2:0]        op;
    logic [4:0]        rd;
    logic [XLEN-1:0]   operand;
    logic [2*XLEN-1:0] acc;
    logic              neg;
    logic [CW-1:0]     cnt;

    logic              is_div, a_sgn, b_sgn, neg_in, div_zero, ovf;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, result;
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] fix32(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] fix64(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    always_comb begin
        is_div   = funct3[2];
        a_sgn    = funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
        b_sgn    = funct3 inside {3'd1, 3'd4, 3'd6};
        // The remainder follows the dividend's sign only, so REM ignores rs2's sign.
        neg_in   = (a_sgn & rs1_data[XLEN-1]) ^ (b_sgn & rs2_data[XLEN-1] & (funct3 != 3'd6));
        a_mag    = magnitude(rs1_data, a_sgn);
        b_mag    = magnitude(rs2_data, b_sgn);
        div_zero = is_div && (rs2_data == '0);
        ovf      = is_div && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
        if (div_zero)
            special_res = funct3[1] ? rs1_data : '1;
        else
            special_res = funct3[1] ? '0 : MIN_NEG;

        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        // Shifted partial remainder needs XLEN+1 bits before the trial subtract.
        div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
        div_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

        prod = fix64(acc, neg);
        case (op)
            3'd0:                result = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    result = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          result = fix32(acc[XLEN-1:0], neg);
            default:             result = fix32(acc[2*XLEN-1:XLEN], neg);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    w_en <= 1'b0;
                    if (start) begin
                        op   <= funct3;
                        rd   <= rd_addr;
                        neg  <= neg_in;
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (div_zero || ovf) begin
                            acc   <= {{XLEN{1'b0}}, special_res};
                            state <= DONE;
                        end else begin
                            operand <= is_div ? b_mag : a_mag;
                            acc     <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt == CW'(XLEN)) begin
                        w_data <= result;
                        w_addr <= rd;
                        done   <= 1'b1;
                        w_en   <= (rd != 5'd0);
                        state  <= DONE;
                    end else begin
                        acc <= op[2] ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Special cases arrive here with done low and get their pulse one cycle later.
                    if (done) begin
                        done  <= 1'b0;
                        w_en  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        w_data <= acc[XLEN-1:0];
                        w_addr <= rd;
                        done   <= 1'b1;
                        w_en   <= (rd != 5'd0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed M-extension ops with hand-computed results.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy, done, w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .busy(busy), .done(done), .w_en(w_en), .w_addr(w_addr), .w_data(w_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        wen;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("w_data", w_data, e.data);
                chk("w_en", {31'd0, w_en}, {31'd0, e.wen});
                chk("w_addr", {27'd0, w_addr}, {27'd0, e.addr});
                chk("latency", cyc - e.acc_cyc, e.lat);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_data,
                         input int lat, input bit push);
        exp_t e;
        wait_idle();
        funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.data = exp_data; e.addr = rd; e.wen = (rd != 5'd0);
            e.acc_cyc = cyc; e.lat = lat;
            exp_q.push_back(e);
        end
        start = 1'b0;
        rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h0BAD_F00D; rd_addr = 5'd31; funct3 = 3'd7;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        // Reset held with start asserted: nothing must move.
        funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4; rd_addr = 5'd1; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_wen", {31'd0, w_en}, 32'd0);
            chk("rst_wdata", w_data, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        e.data = 32'd12; e.addr = 5'd1; e.wen = 1'b1; e.acc_cyc = cyc; e.lat = 33;
        exp_q.push_back(e);
        start = 1'b0;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 1);   // MUL 7 * -3
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, 33, 1); // MULH
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 33, 1); // MULHSU
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, 33, 1); // MULHU
        issue(3'd0, 32'h1234_5678, 32'h10, 5'd9, 32'h2345_6780, 33, 1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33, 1);  // DIV -7/2
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33, 1);  // REM -7/2
        issue(3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 33, 1);                // DIVU
        issue(3'd7, 32'd100, 32'd7, 5'd13, 32'd2, 33, 1);                 // REMU
        issue(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 33, 1);  // DIV 7/-2
        issue(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd15, 32'd1, 33, 1);           // REM 7/-2

        issue(3'd5, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, 1, 1);            // DIVU /0
        issue(3'd6, 32'd9, 32'd0, 5'd17, 32'd9, 1, 1);                    // REM /0
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1, 1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0, 1, 1);

        issue(3'd0, 32'd2, 32'd3, 5'd0, 32'd6, 33, 1);                    // rd = 0

        // A start pulse during CALC must be ignored.
        issue(3'd5, 32'd1000, 32'd10, 5'd20, 32'd100, 33, 1);
        repeat (5) @(negedge clk);
        funct3 = 3'd0; rs1_data = 32'd55; rs2_data = 32'd55; rd_addr = 5'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_calc", {31'd0, busy}, 32'd1);

        // Abort at iteration 10: no completion, outputs cleared.
        issue(3'd3, 32'd123, 32'd456, 5'd22, 32'd0, 33, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_wen", {31'd0, w_en}, 32'd0);
        chk("abort_waddr", {27'd0, w_addr}, 32'd0);
        chk("abort_wdata", w_data, 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        // Back in service after the abort.
        issue(3'd5, 32'd50, 32'd5, 5'd23, 32'd10, 33, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting between the register file read ports and its write port. It accepts rs1/rs2 operand values plus a destination index when the decoder issues an M-extension instruction. It computes the result over multiple cycles with a radix-2 shift-add or restoring-divide datapath. It then presents a one-cycle write request (enable, address, data) for the register file's write port.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue strobe; sampled only while idle.
- funct3  in  3  M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  in  XLEN  operand A (dividend / multiplicand).
- rs2_data  in  XLEN  operand B (divisor / multiplier).
- rd_addr  in  5  destination register index.
- busy  out  1  high from the cycle after acceptance until `done` completes.
- done  out  1  one-cycle completion pulse.
- w_en  out  1  register-file write enable; equals `done` when rd ≠ 0, else 0.
- w_addr  out  5  latched rd_addr.
- w_data  out  XLEN  result; held until the next completion or reset.

## Operation
- States: IDLE, CALC, DONE.
- IDLE
  - `start`=1 latches funct3, rd_addr, and operands.
  - Signed ops are converted to magnitudes plus a result-sign flag. MULH: both signed. MULHSU: rs1 signed only. DIV/REM: both signed.
  - Counter cleared to 0.
  - Next state is CALC, except for the special cases below, which go directly to DONE.
- CALC, multiply
  - Each cycle: if the multiplier LSB is set, add the multiplicand into the upper half of a 64-bit accumulator; then shift right 1.
- CALC, divide
  - Each cycle, restoring step: shift {rem, quot} left 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- CALC, completion
  - After 32 iterations (counter 0..31), apply the sign fix (two's-complement negate when the sign flag is set) and load `w_data`.
  - MUL uses the low 32 product bits; MULH/MULHSU/MULHU use the high 32.
  - DIV/DIVU return the quotient; REM/REMU return the remainder. The remainder takes the dividend's sign.
  - Next state is DONE.
- DONE
  - `done`=1, `w_en`=(w_addr≠0), `busy`=1 for one cycle, then IDLE.
- Special cases, resolved in IDLE with no iterations:
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = rs1_data.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- `start` while not IDLE is ignored; no queueing.
- rd_addr = 0: computation runs normally and `done` pulses, but `w_en` stays 0.
- Operand inputs are don't-care after the acceptance edge.

## Timing
- Reset: state IDLE; busy, done, w_en = 0; w_addr = 0; w_data = 0; counter = 0.
- Reset mid-operation aborts on the next edge. No write is issued and the latched operation is discarded.
- `start` sampled high at edge k (IDLE):
  - Normal op: busy high from k through k+33; done/w_en high from k+33 to k+34; w_data valid from k+33.
  - Special case: done from k+1 to k+2.
- A new `start` can be accepted at edge k+34 (normal) or k+2 (special), i.e. the first edge back in IDLE. Back-to-back issue is therefore 34 cycles apart.
- `rst` and `start` together: reset wins.

## Test plan
- Reset with start held high:
  - busy, done, w_en, w_data stay 0.
  - Release reset: the op is accepted at the first edge and completes 33 cycles later.
- MUL 7 × −3, rd=5:
  - done exactly 33 cycles after acceptance.
  - w_data = 0xFFFFFFEB, w_en = 1, w_addr = 5.
- MULH / MULHSU / MULHU with 0xFFFFFFFF × 0xFFFFFFFF:
  - MULH = 0x00000000.
  - MULHSU = 0xFFFFFFFF.
  - MULHU = 0xFFFFFFFE.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Special cases, each with done one cycle after acceptance:
  - DIVU x / 0 → 0xFFFFFFFF.
  - REM 9 / 0 → 9.
  - DIV 0x80000000 / −1 → 0x80000000.
  - REM 0x80000000 / −1 → 0.
- Misc control:
  - rd=0 op: done pulses, w_en stays 0.
  - start pulsed during CALC: ignored, result unaffected.
  - rst asserted at iteration 10: no done or w_en, and outputs return to 0.
